// File: rtl/capture_ctrl_if.sv
// Capture controller port bundle: strobe/trigger/command inputs and RAM/status outputs.
// Latency: none (wires only).
// Backpressure: none; the environment drives the master side, capture_ctrl is the slave.
interface capture_ctrl_if #(
  parameter int LOG2 = 9
);
  logic            run;
  logic            clr_cap_done;
  logic            wrt_smpl;
  logic            trig;
  logic [LOG2-1:0] trig_pos;
  logic            armed;
  logic            capture_done;
  logic            we;
  logic [LOG2-1:0] waddr;
  logic [LOG2-1:0] trig_addr;
  logic            busy;

  modport master (
    output run, clr_cap_done, wrt_smpl, trig, trig_pos,
    input  armed, capture_done, we, waddr, trig_addr, busy
  );

  modport slave (
    input  run, clr_cap_done, wrt_smpl, trig, trig_pos,
    output armed, capture_done, we, waddr, trig_addr, busy
  );
endinterface

// File: rtl/capture_ctrl.sv
// Circular-buffer capture sequencer: pre-trigger fill, armed wait, post-trigger count, done.
// Latency: we is combinational from wrt_smpl; armed/capture_done rise one cycle after the qualifying event.
// Backpressure: none; every strobe in a capture state is written, capture_done holds until cleared.
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input logic           clk,
  input logic           rst_n,
  capture_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRETRIG  = 3'd1;
  localparam logic [2:0] S_ARMED    = 3'd2;
  localparam logic [2:0] S_POSTTRIG = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [LOG2:0] ENT  = (LOG2+1)'(ENTRIES);
  localparam logic [LOG2:0] LAST = (LOG2+1)'(ENTRIES - 1);

  logic [2:0]      state;
  logic [LOG2:0]   smpl_cnt;
  logic [LOG2-1:0] trig_cnt;
  logic [LOG2-1:0] waddr;
  logic [LOG2-1:0] trig_addr;
  logic            armed;
  logic            capture_done;

  logic [LOG2:0]   tp_ext;
  logic [LOG2-1:0] tp_eff;
  logic [LOG2:0]   arm_thresh;
  logic [LOG2:0]   smpl_nxt;
  logic [LOG2-1:0] trig_nxt;
  logic [LOG2-1:0] waddr_inc;
  logic            capturing;
  logic            wr;

  // Clamp the post-trigger count at full width so large trig_pos values never alias.
  assign tp_ext     = {1'b0, bus.trig_pos};
  assign tp_eff     = (tp_ext > LAST) ? LAST[LOG2-1:0] : bus.trig_pos;
  assign arm_thresh = ENT - {1'b0, tp_eff};
  assign smpl_nxt   = smpl_cnt + (LOG2+1)'(1);
  assign trig_nxt   = trig_cnt + LOG2'(1);
  assign waddr_inc  = (waddr == LAST[LOG2-1:0]) ? '0 : waddr + LOG2'(1);
  assign capturing  = (state == S_PRETRIG) || (state == S_ARMED) || (state == S_POSTTRIG);
  assign wr         = capturing && bus.wrt_smpl;

  assign bus.we           = wr;
  assign bus.waddr        = waddr;
  assign bus.trig_addr    = trig_addr;
  assign bus.armed        = armed;
  assign bus.capture_done = capture_done;
  assign bus.busy         = capturing;

  // Capture sequencing, write address advance and trigger bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      smpl_cnt     <= '0;
      trig_cnt     <= '0;
      waddr        <= '0;
      trig_addr    <= '0;
      armed        <= 1'b0;
      capture_done <= 1'b0;
    end else begin
      if (wr) waddr <= waddr_inc;
      case (state)
        S_IDLE: begin
          if (bus.run && !capture_done) begin
            state    <= S_PRETRIG;
            waddr    <= '0;
            smpl_cnt <= '0;
            trig_cnt <= '0;
          end
        end
        S_PRETRIG: begin
          if (!bus.run) begin
            state <= S_IDLE;
          end else if (wr) begin
            smpl_cnt <= smpl_nxt;
            if (smpl_nxt == arm_thresh) begin
              state <= S_ARMED;
              armed <= 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (bus.trig) begin
            // A write in the trigger cycle is still pre-trigger, so the
            // first post-trigger sample lands at the advanced address.
            trig_addr <= wr ? waddr_inc : waddr;
            trig_cnt  <= '0;
          end
          if (bus.trig && tp_eff == '0) begin
            state        <= S_DONE;
            capture_done <= 1'b1;
            armed        <= 1'b0;
          end else if (!bus.run) begin
            state <= S_IDLE;
            armed <= 1'b0;
          end else if (bus.trig) begin
            state <= S_POSTTRIG;
          end
        end
        S_POSTTRIG: begin
          // Completion outranks a run drop in the same cycle.
          if (wr && trig_nxt == tp_eff) begin
            state        <= S_DONE;
            capture_done <= 1'b1;
            armed        <= 1'b0;
          end else if (!bus.run) begin
            state <= S_IDLE;
            armed <= 1'b0;
          end else if (wr) begin
            trig_cnt <= trig_nxt;
          end
        end
        S_DONE: begin
          if (bus.clr_cap_done) begin
            state        <= S_IDLE;
            capture_done <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl with a write-count based reference model.
// Latency: model expectations are compared every falling edge plus targeted scenario checks.
// Backpressure: not applicable; the bench drives strobes freely.
module tb_capture_ctrl;
  localparam int E  = 384;
  localparam int LG = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  capture_ctrl_if #(.LOG2(LG)) b ();

  capture_ctrl #(.ENTRIES(E), .LOG2(LG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  always #5 clk = ~clk;

  // Reference model: everything is derived from the number of writes since capture start.
  bit m_active = 0;
  bit m_done   = 0;
  bit m_trig   = 0;
  int m_wr     = 0;
  int m_post0  = 0;
  int m_taddr  = 0;

  function automatic int tpe();
    return (int'(b.trig_pos) > E - 1) ? E - 1 : int'(b.trig_pos);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_trig = 0; m_wr = 0; m_post0 = 0; m_taddr = 0;
    end else begin
      int tp;
      bit wr;
      bit fin;
      tp  = tpe();
      wr  = b.wrt_smpl;
      fin = 0;
      if (m_active) begin
        if (m_trig) begin
          if (wr && (m_wr + 1 - m_post0) == tp) fin = 1;
        end else if (b.trig && m_wr >= E - tp) begin
          m_taddr = (m_wr + int'(wr)) % E;
          if (tp == 0) fin = 1;
          else begin
            m_trig  = 1;
            m_post0 = m_wr + int'(wr);
          end
        end
        if (wr) m_wr++;
        if (fin) begin
          m_active = 0;
          m_done   = 1;
        end else if (!b.run) begin
          m_active = 0;
        end
      end else if (m_done) begin
        if (b.clr_cap_done) m_done = 0;
      end else if (b.run) begin
        m_active = 1; m_wr = 0; m_trig = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("armed", b.armed, (m_active && m_wr >= E - tpe()));
      check("capture_done", b.capture_done, m_done);
      check("we", b.we, (m_active && b.wrt_smpl));
      check("waddr", b.waddr, m_wr % E);
      check("trig_addr", b.trig_addr, m_taddr);
      check("busy", b.busy, m_active);
    end
  end

  task automatic drive(input bit w, input bit t, input bit c);
    b.wrt_smpl = w; b.trig = t; b.clr_cap_done = c;
    @(posedge clk); #1;
    b.wrt_smpl = 0; b.trig = 0; b.clr_cap_done = 0;
  endtask

  task automatic wr_n(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0);
      repeat (gap) drive(0, 0, 0);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_armed"}, b.armed, 0);
    check({pfx, "_done"}, b.capture_done, 0);
    check({pfx, "_we"}, b.we, 0);
    check({pfx, "_waddr"}, b.waddr, 0);
    check({pfx, "_taddr"}, b.trig_addr, 0);
    check({pfx, "_busy"}, b.busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    b.run = 0; b.clr_cap_done = 0; b.wrt_smpl = 1; b.trig = 0; b.trig_pos = '0;
    #3;
    check_all_zero("rst");
    b.wrt_smpl = 0;
    #20 rst_n = 1;
    @(posedge clk); #1;

    // trig_pos=100, one strobe every 4 cycles
    b.trig_pos = 9'd100; b.run = 1;
    drive(0, 0, 0);
    n = 0;
    while (!b.armed && n < 1000) begin wr_n(1, 3); n++; end
    check("arm_writes_tp100", n, 284);
    drive(0, 1, 0);
    check("trig_addr_tp100", b.trig_addr, 284);
    wr_n(100, 3);
    check("done_tp100", b.capture_done, 1);
    check("done_armed_tp100", b.armed, 0);
    check("done_busy_tp100", b.busy, 0);
    check("done_waddr_tp100", b.waddr, (284 + 100) % E);
    b.wrt_smpl = 1; #1;
    check("done_we_blocked", b.we, 0);
    b.wrt_smpl = 0;
    drive(0, 0, 1);
    check("clr_idle_busy", b.busy, 0);
    check("clr_idle_done", b.capture_done, 0);
    drive(0, 0, 0);
    check("restart_busy", b.busy, 1);
    check("restart_waddr", b.waddr, 0);

    // abort mid-PRETRIG
    wr_n(10, 0);
    b.run = 0;
    drive(0, 0, 0);
    check("abort_busy", b.busy, 0);
    check("abort_armed", b.armed, 0);
    check("abort_done", b.capture_done, 0);
    check("abort_waddr_held", b.waddr, 10);
    b.wrt_smpl = 1; #1;
    check("abort_we", b.we, 0);
    b.wrt_smpl = 0;
    drive(0, 0, 0);

    // long armed wait with wrap, ignored trig pulses, simultaneous trig+write at 383
    b.trig_pos = 9'd50; b.run = 1;
    drive(0, 0, 0);
    n = 0;
    while (!b.armed && n < 2000) begin
      drive(1, 0, 0);
      repeat ($urandom_range(0, 2)) drive(0, (!b.armed && $urandom_range(0, 2) == 0), 0);
      n++;
    end
    check("arm_writes_tp50", n, E - 50);
    for (int i = 0; i < 500; i++) begin
      drive(1, 0, 0);
      repeat ($urandom_range(0, 2)) drive(0, 0, 0);
    end
    n = 0;
    while ((m_wr % E) != E - 1 && n < 400) begin drive(1, 0, 0); n++; end
    check("reach_383", b.waddr, E - 1);
    drive(1, 1, 0);
    check("trig_addr_wrap", b.trig_addr, 0);
    for (int i = 0; i < 50; i++) begin
      drive(1, 0, 0);
      repeat ($urandom_range(0, 2)) drive(0, $urandom_range(0, 1) == 1, 0);
    end
    check("done_wrap", b.capture_done, 1);
    check("oldest_wrap", b.waddr, 50);
    b.run = 0;
    drive(0, 0, 1);

    // trig_pos=0: arm after full buffer, trig completes with no writes
    b.trig_pos = 9'd0; b.run = 1;
    drive(0, 0, 0);
    n = 0;
    while (!b.armed && n < 1000) begin drive(1, 0, 0); n++; end
    check("arm_writes_tp0", n, E);
    drive(0, 1, 0);
    check("done_tp0", b.capture_done, 1);
    check("done_armed_tp0", b.armed, 0);
    check("done_waddr_tp0", b.waddr, 0);
    b.run = 0;
    drive(0, 0, 1);

    // trig_pos=500 clamps to 383; then async reset mid-POSTTRIG
    b.trig_pos = 9'd500; b.run = 1;
    drive(0, 0, 0);
    n = 0;
    while (!b.armed && n < 1000) begin drive(1, 0, 0); n++; end
    check("arm_writes_tp500", n, 1);
    drive(0, 1, 0);
    wr_n(5, 1);
    check("posttrig_busy", b.busy, 1);
    #2 rst_n = 0;
    b.wrt_smpl = 1;
    #1;
    check_all_zero("arst");
    b.wrt_smpl = 0; b.run = 0;
    @(posedge clk); #1;
    rst_n = 1;
    drive(0, 0, 0);

    // randomized traffic
    b.trig_pos = 9'd20; b.run = 1;
    for (int i = 0; i < 4000; i++) begin
      if (!b.busy && $urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: b.trig_pos = 9'd0;
          1: b.trig_pos = 9'd500;
          2: b.trig_pos = 9'($urandom_range(1, 383));
          default: b.trig_pos = 9'd383;
        endcase
      end
      if ($urandom_range(0, 199) == 0) b.run = ~b.run;
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Parametrised capture controller for one logic-analyzer channel group. It sequences a circular RAM write through pre-trigger fill, armed, post-trigger count and done. It generates the RAM write enable and address, records the trigger address, and holds a sticky capture_done flag that the command/config block clears. The block sits between the sample-rate strobe generator, the trigger logic, and the RAM queues.

## Interface
- ENTRIES, 384: buffer depth in samples (12288 on the DE0 build).
- LOG2, 9: address/count width; ceil(log2(ENTRIES)).

- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- run  in  1  level; a capture starts or continues while high.
- clr_cap_done  in  1  one-cycle pulse from cmd_cfg; releases DONE.
- wrt_smpl  in  1  one-cycle sample strobe.
- trig  in  1  trigger event from trigger logic. Only qualified while armed=1.
- trig_pos  in  LOG2  number of post-trigger samples.
- armed  out  1  registered; enables the trigger logic.
- capture_done  out  1  registered; sticky capture-complete flag.
- we  out  1  RAM write enable; combinational.
- waddr  out  LOG2  RAM write address. In DONE it is the address of the oldest sample.
- trig_addr  out  LOG2  address of the first post-trigger sample.
- busy  out  1  high in PRETRIG, ARMED and POSTTRIG.

## Operation
- tp_eff = min(trig_pos, ENTRIES-1). The comparison is done at LOG2+1 bits, with no truncation.
- States and transitions:
  - IDLE → PRETRIG when run=1 and capture_done=0. On this transition, waddr, smpl_cnt and trig_cnt are cleared to 0.
  - PRETRIG → ARMED when a write brings smpl_cnt to ENTRIES − tp_eff. The next cycle has armed=1.
  - ARMED → POSTTRIG on trig=1. On this transition, trig_addr is set to the post-increment waddr (the address of the next sample) and trig_cnt is cleared.
  - ARMED → DONE directly on trig=1 when tp_eff=0. This sets capture_done and clears armed.
  - POSTTRIG → DONE when a write brings trig_cnt to tp_eff. This sets capture_done and clears armed.
  - DONE → IDLE on clr_cap_done.
- Any capture state (PRETRIG, ARMED, POSTTRIG) → IDLE if run=0 (abort). Abort clears armed and leaves capture_done at 0.
- Write rule: in PRETRIG, ARMED and POSTTRIG, we = wrt_smpl.
  - waddr increments on each write.
  - waddr wraps from ENTRIES−1 to 0. It never reaches ENTRIES.
- smpl_cnt counts pre-trigger writes only. It stops once armed.
- trig is ignored in IDLE, PRETRIG, POSTTRIG and DONE.
- In DONE and IDLE, we=0 and waddr/trig_addr hold their values for readout.
- clr_cap_done outside DONE has no effect.
- After DONE → IDLE, a new capture starts only when run=1 and capture_done=0, so a run left high restarts the cycle after the clear.

## Timing
- Reset values: state IDLE; armed 0; capture_done 0; we 0; waddr 0; trig_addr 0; busy 0; smpl_cnt and trig_cnt 0.
- we has zero latency from wrt_smpl and writes to the current waddr. waddr advances the next cycle.
- armed rises 1 cycle after the qualifying write.
- capture_done rises 1 cycle after the final post-trigger write, or 1 cycle after trig when tp_eff=0.
- trig and wrt_smpl in the same ARMED cycle:
  - The write is a pre-trigger sample.
  - trig_addr = waddr+1 (with wrap).
- The final post-trigger write in the same cycle as run falling: DONE takes priority.
- Reset mid-capture returns everything to its reset value immediately.
- wrt_smpl is at most 1 per cycle. Back-to-back strobes every cycle are legal.
- Total samples per capture = ENTRIES exactly. (ENTRIES − tp_eff) pre-trigger samples + tp_eff post-trigger samples, excluding pre-trigger writes made while armed and waiting.

## Test plan
- ENTRIES=384, trig_pos=100, wrt_smpl every 4 cycles:
  - armed rises after write #284.
  - Pulse trig → trig_addr = current waddr.
  - After 100 more writes → capture_done=1, armed=0, busy=0.
  - waddr = (trig_addr+100) mod 384.
- Wrap: hold ARMED for 500 extra writes before trig → waddr sequence 383→0 with no out-of-range value. After done, waddr = oldest sample.
- trig_pos=0 → armed after 384 writes; trig → capture_done the next cycle with no further writes. trig_pos=500 → armed after write #1 (tp_eff=383).
- trig pulses during PRETRIG and POSTTRIG → no state change. Simultaneous trig+wrt_smpl in ARMED with waddr=383 → trig_addr=0.
- Drop run mid-PRETRIG → IDLE, armed=0, capture_done=0, we=0 on later strobes.
- In DONE, with run held high: further strobes → we=0. clr_cap_done → the cycle after returns to IDLE, next cycle PRETRIG with waddr=0. Assert rst_n mid-POSTTRIG → all outputs 0 asynchronously.
